// File: rtl/wb_queue.sv
// wb_queue: write-back queue between the result-producing units and the
// register file's single write port.
//
// Completed results {addr, data} are buffered in a DEPTH-entry FIFO. The
// queue drains one entry per cycle into the register file whenever the
// write port is free. Operand reads can forward values that are still
// pending in the queue.
//
// Ports
//   iClk, iRst             clock; asynchronous active-high reset
//   iValid/oReady          producer handshake (oReady == !oFull)
//   iAddr, iData           incoming result (address 0 is accepted but dropped)
//   iHold                  register-file write port busy; suppresses drain
//   oWrite, oAddrC, oRegC  register-file write port (head entry, 0/0 when empty)
//   iLookA/B               operand read addresses
//   oHitA/B, oFwdA/B       newest pending value for iLookA/B (0 on miss)
//   oCount, oEmpty, oFull  occupancy
module wb_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                     iClk,
  input  logic                     iRst,
  input  logic                     iValid,
  output logic                     oReady,
  input  logic [ADDR_W-1:0]        iAddr,
  input  logic [DATA_W-1:0]        iData,
  input  logic                     iHold,
  output logic                     oWrite,
  output logic [ADDR_W-1:0]        oAddrC,
  output logic [DATA_W-1:0]        oRegC,
  input  logic [ADDR_W-1:0]        iLookA,
  input  logic [ADDR_W-1:0]        iLookB,
  output logic                     oHitA,
  output logic                     oHitB,
  output logic [DATA_W-1:0]        oFwdA,
  output logic [DATA_W-1:0]        oFwdB,
  output logic [$clog2(DEPTH):0]   oCount,
  output logic                     oEmpty,
  output logic                     oFull
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [CW-1:0]     count;
  logic              push_en;
  logic              drain_en;

  // Search the occupied entries oldest to newest so the newest match
  // overrides any older one. Register 0 never hits.
  function automatic logic [DATA_W:0] lookup(input logic [ADDR_W-1:0] look);
    logic [DATA_W:0] res;
    logic [PW-1:0]   idx;
    res = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if ((CW'(i) < count) && (look != '0) && (addr_mem[idx] == look))
        res = {1'b1, data_mem[idx]};
    end
    return res;
  endfunction

  assign oEmpty = (count == '0);
  assign oFull  = (count == CW'(DEPTH));
  assign oReady = !oFull;
  assign oCount = count;

  // A push to register 0 completes the handshake but is not stored.
  assign push_en  = iValid && oReady && (iAddr != '0);
  assign oWrite   = !oEmpty && !iHold;
  assign drain_en = oWrite;

  // Storage keeps stale data after a drain, so mask the port when empty.
  assign oAddrC = oEmpty ? '0 : addr_mem[head];
  assign oRegC  = oEmpty ? '0 : data_mem[head];

  assign {oHitA, oFwdA} = lookup(iLookA);
  assign {oHitB, oFwdB} = lookup(iLookB);

  // Queue state: enqueue at tail, dequeue at head.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem[i] <= '0;
        data_mem[i] <= '0;
      end
    end else begin
      if (push_en) begin
        addr_mem[tail] <= iAddr;
        data_mem[tail] <= iData;
        tail           <= tail + PW'(1);
      end
      if (drain_en)
        head <= head + PW'(1);
      case ({push_en, drain_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_queue.sv
module tb_wb_queue;
  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              valid = 1'b0;
  logic              ready;
  logic [ADDR_W-1:0] addr = '0;
  logic [DATA_W-1:0] data = '0;
  logic              hold = 1'b0;
  logic              wr;
  logic [ADDR_W-1:0] addrc;
  logic [DATA_W-1:0] regc;
  logic [ADDR_W-1:0] looka = '0;
  logic [ADDR_W-1:0] lookb = '0;
  logic              hita, hitb;
  logic [DATA_W-1:0] fwda, fwdb;
  logic [$clog2(DEPTH):0] cnt;
  logic              empty, full;

  wb_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .iClk(clk), .iRst(rst), .iValid(valid), .oReady(ready),
    .iAddr(addr), .iData(data), .iHold(hold),
    .oWrite(wr), .oAddrC(addrc), .oRegC(regc),
    .iLookA(looka), .iLookB(lookb),
    .oHitA(hita), .oHitB(hitb), .oFwdA(fwda), .oFwdB(fwdb),
    .oCount(cnt), .oEmpty(empty), .oFull(full)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nmis = 0;

  // Reference model: a plain queue of pending {addr, data}, oldest first.
  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } ent_t;
  ent_t q[$];

  typedef struct {
    logic              v;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic              h;
    logic [ADDR_W-1:0] la;
    logic [ADDR_W-1:0] lb;
    logic              ew;
    logic [ADDR_W-1:0] eac;
    logic [DATA_W-1:0] erc;
    int                ecnt;
    logic              erdy;
    logic              eha;
    logic [DATA_W-1:0] efa;
    logic              ehb;
    logic [DATA_W-1:0] efb;
  } vec_t;

  vec_t tbl[21];

  function automatic vec_t mk(logic v, logic [ADDR_W-1:0] a, logic [DATA_W-1:0] d,
                              logic h, logic [ADDR_W-1:0] la, logic [ADDR_W-1:0] lb,
                              logic ew, logic [ADDR_W-1:0] eac, logic [DATA_W-1:0] erc,
                              int ecnt, logic erdy, logic eha, logic [DATA_W-1:0] efa,
                              logic ehb, logic [DATA_W-1:0] efb);
    vec_t r;
    r.v = v; r.a = a; r.d = d; r.h = h; r.la = la; r.lb = lb;
    r.ew = ew; r.eac = eac; r.erc = erc; r.ecnt = ecnt; r.erdy = erdy;
    r.eha = eha; r.efa = efa; r.ehb = ehb; r.efb = efb;
    return r;
  endfunction

  function automatic void model_look(input logic [ADDR_W-1:0] look,
                                     output logic hit, output logic [DATA_W-1:0] val);
    hit = 1'b0;
    val = '0;
    if (look != '0) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].a == look) begin
          hit = 1'b1;
          val = q[i].d;
          break;
        end
      end
    end
  endfunction

  // Compare every DUT output with the expected values given.
  task automatic compare(input string tag, input logic ew, input logic [ADDR_W-1:0] eac,
                         input logic [DATA_W-1:0] erc, input int ecnt, input logic erdy,
                         input logic eha, input logic [DATA_W-1:0] efa,
                         input logic ehb, input logic [DATA_W-1:0] efb);
    logic eempty, efull;
    eempty = (ecnt == 0);
    efull  = (ecnt == DEPTH);
    nvec++;
    if (wr !== ew || addrc !== eac || regc !== erc || int'(cnt) != ecnt ||
        ready !== erdy || empty !== eempty || full !== efull ||
        hita !== eha || fwda !== efa || hitb !== ehb || fwdb !== efb) begin
      nmis++;
      $display("FAIL %s: got wr=%0b ac=%0d rc=%h cnt=%0d rdy=%0b emp=%0b ful=%0b hA=%0b fA=%h hB=%0b fB=%h | exp wr=%0b ac=%0d rc=%h cnt=%0d rdy=%0b emp=%0b ful=%0b hA=%0b fA=%h hB=%0b fB=%h",
               tag, wr, addrc, regc, cnt, ready, empty, full, hita, fwda, hitb, fwdb,
               ew, eac, erc, ecnt, erdy, eempty, efull, eha, efa, ehb, efb);
    end
  endtask

  task automatic check_model(input string tag);
    logic              ew, eha, ehb;
    logic [ADDR_W-1:0] eac;
    logic [DATA_W-1:0] erc, efa, efb;
    ew  = (q.size() > 0) && !hold;
    eac = (q.size() > 0) ? q[0].a : '0;
    erc = (q.size() > 0) ? q[0].d : '0;
    model_look(looka, eha, efa);
    model_look(lookb, ehb, efb);
    compare(tag, ew, eac, erc, q.size(), q.size() < DEPTH, eha, efa, ehb, efb);
  endtask

  // Called just after a rising edge: drive, check mid-cycle, advance the model.
  task automatic run_cycle(input string tag, input logic v, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d, input logic h,
                           input logic [ADDR_W-1:0] la, input logic [ADDR_W-1:0] lb);
    logic do_push, do_pop;
    valid = v; addr = a; data = d; hold = h; looka = la; lookb = lb;
    @(negedge clk);
    check_model(tag);
    do_push = v && (q.size() < DEPTH) && (a != '0);
    do_pop  = (q.size() > 0) && !h;
    @(posedge clk);
    if (do_pop) void'(q.pop_front());
    if (do_push) q.push_back({a, d});
    #1;
  endtask

  initial begin
    // Directed per-cycle vectors, starting from an empty queue.
    tbl[0]  = mk(1, 3, 32'hDEADBEEF, 0, 3, 0,  0, 0, 0,            0, 1, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0,            0, 3, 3,  1, 3, 32'hDEADBEEF, 1, 1, 1, 32'hDEADBEEF, 1, 32'hDEADBEEF);
    tbl[2]  = mk(0, 0, 0,            0, 3, 0,  0, 0, 0,            0, 1, 0, 0, 0, 0);
    tbl[3]  = mk(1, 1, 32'h11,       1, 1, 0,  0, 0, 0,            0, 1, 0, 0, 0, 0);
    tbl[4]  = mk(1, 2, 32'h22,       1, 1, 2,  0, 1, 32'h11,       1, 1, 1, 32'h11, 0, 0);
    tbl[5]  = mk(1, 3, 32'h33,       1, 2, 3,  0, 1, 32'h11,       2, 1, 1, 32'h22, 0, 0);
    tbl[6]  = mk(1, 4, 32'h44,       1, 3, 4,  0, 1, 32'h11,       3, 1, 1, 32'h33, 0, 0);
    tbl[7]  = mk(1, 5, 32'h55,       1, 4, 5,  0, 1, 32'h11,       4, 0, 1, 32'h44, 0, 0);
    tbl[8]  = mk(0, 0, 0,            0, 5, 1,  1, 1, 32'h11,       4, 0, 0, 0, 1, 32'h11);
    tbl[9]  = mk(0, 0, 0,            0, 2, 1,  1, 2, 32'h22,       3, 1, 1, 32'h22, 0, 0);
    tbl[10] = mk(0, 0, 0,            0, 4, 0,  1, 3, 32'h33,       2, 1, 1, 32'h44, 0, 0);
    tbl[11] = mk(0, 0, 0,            0, 4, 0,  1, 4, 32'h44,       1, 1, 1, 32'h44, 0, 0);
    tbl[12] = mk(0, 0, 0,            0, 4, 0,  0, 0, 0,            0, 1, 0, 0, 0, 0);
    tbl[13] = mk(1, 7, 32'hA,        1, 7, 5,  0, 0, 0,            0, 1, 0, 0, 0, 0);
    tbl[14] = mk(1, 7, 32'hB,        1, 7, 5,  0, 7, 32'hA,        1, 1, 1, 32'hA, 0, 0);
    tbl[15] = mk(0, 0, 0,            1, 7, 5,  0, 7, 32'hA,        2, 1, 1, 32'hB, 0, 0);
    tbl[16] = mk(0, 0, 0,            0, 7, 5,  1, 7, 32'hA,        2, 1, 1, 32'hB, 0, 0);
    tbl[17] = mk(0, 0, 0,            0, 7, 5,  1, 7, 32'hB,        1, 1, 1, 32'hB, 0, 0);
    tbl[18] = mk(0, 0, 0,            0, 7, 5,  0, 0, 0,            0, 1, 0, 0, 0, 0);
    tbl[19] = mk(1, 0, 32'hFFFF,     0, 0, 0,  0, 0, 0,            0, 1, 0, 0, 0, 0);
    tbl[20] = mk(0, 0, 0,            0, 0, 0,  0, 0, 0,            0, 1, 0, 0, 0, 0);

    // Reset state while reset is held.
    repeat (2) @(posedge clk);
    #1;
    compare("reset_state", 0, 0, 0, 0, 1, 0, 0, 0, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 21; i++) begin
      valid = tbl[i].v; addr = tbl[i].a; data = tbl[i].d; hold = tbl[i].h;
      looka = tbl[i].la; lookb = tbl[i].lb;
      @(negedge clk);
      compare($sformatf("vec%0d", i), tbl[i].ew, tbl[i].eac, tbl[i].erc, tbl[i].ecnt,
              tbl[i].erdy, tbl[i].eha, tbl[i].efa, tbl[i].ehb, tbl[i].efb);
      @(posedge clk);
      #1;
    end

    // Mid-cycle asynchronous reset with entries pending.
    q.delete();
    run_cycle("rst_fill0", 1, 9,  32'h99, 1, 0, 0);
    run_cycle("rst_fill1", 1, 10, 32'hAA, 1, 0, 0);
    run_cycle("rst_fill2", 1, 11, 32'hBB, 1, 9, 11);
    valid = 1'b0; hold = 1'b0; looka = 9; lookb = 11;
    #1;
    check_model("rst_pre");
    rst = 1'b1;
    #1;
    q.delete();
    check_model("rst_async");
    repeat (2) @(posedge clk);
    #1;
    check_model("rst_held");
    rst = 1'b0;
    for (int i = 0; i < 3; i++)
      run_cycle($sformatf("rst_idle%0d", i), 0, 0, 0, 0, 9, 11);

    // Back-to-back stream that wraps the pointers.
    for (int i = 0; i < 10; i++)
      run_cycle($sformatf("stream%0d", i), 1, ADDR_W'(i + 1), DATA_W'(i), 0,
                ADDR_W'(i + 1), ADDR_W'(i));
    run_cycle("stream_end", 0, 0, 0, 0, 10, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++)
      run_cycle($sformatf("rand%0d", i), 1'($urandom_range(0, 1)),
                ADDR_W'($urandom_range(0, 7)), $urandom,
                ($urandom_range(0, 2) == 0),
                ADDR_W'($urandom_range(0, 7)), ADDR_W'($urandom_range(0, 7)));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule

// File: doc/wb_queue.md
# wb_queue

Write-back queue that sits between the CPU's result-producing units and the register file's single write port (address C / data C / write enable). It buffers completed results in a small FIFO, drains them one per cycle into the register file, and gives the operand-read side forwarding of values still pending in the queue. This closes the stale-read window between a result completing and its register-file write.

## Interface
Parameters:
- DEPTH, 4: queue entries; a power of two, ≥ 2.
- DATA_W, 32: result width; matches the register file.
- ADDR_W, 5: register address width.

Ports:
- iClk  in  1  clock; all state updates on the rising edge.
- iRst  in  1  reset, asynchronous and active-high.
- iValid  in  1  producer has a result.
- oReady  out  1  queue can accept; equal to !oFull.
- iAddr  in  ADDR_W  destination register of the result.
- iData  in  DATA_W  result value.
- iHold  in  1  register-file write port unavailable this cycle; suppresses drain.
- oWrite  out  1  write enable to the register file.
- oAddrC  out  ADDR_W  write address to the register file.
- oRegC  out  DATA_W  write data to the register file.
- iLookA, iLookB  in  ADDR_W  read addresses currently presented to register file ports A and B.
- oHitA, oHitB  out  1  a pending entry matches iLookA / iLookB.
- oFwdA, oFwdB  out  DATA_W  newest pending value for iLookA / iLookB; 0 when there is no hit.
- oCount  out  clog2(DEPTH)+1  occupied entries.
- oEmpty, oFull  out  1  oCount == 0 and oCount == DEPTH.

## Operation
- Storage: DEPTH entries of {addr, data}, with head and tail pointers of clog2(DEPTH) bits that wrap modulo DEPTH, and a count.
- Push:
  - Occurs when iValid && oReady at a rising edge. {iAddr, iData} is written at tail, tail increments and count increments.
  - A push with iAddr == 0 completes the handshake but is discarded: nothing is enqueued and count is unchanged. Register 0 is never written.
- Drain:
  - oWrite = !oEmpty && !iHold.
  - oAddrC and oRegC always show the head entry; they show 0/0 when empty.
  - When oWrite is 1 at a rising edge, the register file captures the entry, head increments and count decrements.
- Push and drain on the same edge: count is unchanged and both pointers advance.
- Full: oReady = 0. There is no pass-through, so a drain in the same cycle does not raise oReady until the next cycle.
- Lookup (combinational):
  - Compare iLookX against every occupied entry, including the head being written this cycle.
  - When several entries match, the newest (closest to tail) wins.
  - iLookX == 0 never hits.
  - The incoming push (iAddr/iData) is not searched.
- Reset: head = tail = count = 0 and all entry storage cleared to 0. The resulting outputs are:
  - oWrite = 0, oAddrC = 0, oRegC = 0
  - oHitA/B = 0, oFwdA/B = 0
  - oEmpty = 1, oFull = 0, oReady = 1
- Reset asserted mid-operation drops all pending entries immediately (asynchronously). No partial write is issued after reset asserts.

## Timing
- Push at edge k: the entry is visible to lookup from edge k onward, and oWrite is high in the cycle after edge k (if it is at the head and iHold = 0). The register file captures it at edge k+1. Push-to-write latency is 1 cycle.
- Sustained throughput is 1 push and 1 drain per cycle with no bubbles when iHold = 0.
- iHold held for N cycles: the head is retained and oWrite stays low. Up to DEPTH pushes are absorbed, then oReady drops.
- oCount, oEmpty, oFull and oReady are registered-state derived and are valid from the cycle after the edge that changed them.
- Lookup outputs settle combinationally within the same cycle as iLookX and the queue state.

## Test plan
- Reset: assert iRst asynchronously mid-cycle → oWrite = 0, oCount = 0, oEmpty = 1, oReady = 1 immediately; hold 2 cycles, release, then no writes issue.
- Single push {3, 0xDEADBEEF} into an empty queue with iHold = 0:
  - Next cycle: oWrite = 1, oAddrC = 3, oRegC = 0xDEADBEEF, oCount = 1.
  - One cycle later: oWrite = 0, oEmpty = 1.
- Fill under hold: iHold = 1, push addr 1..4 with data 0x11..0x44 → oFull = 1, oReady = 0, and a 5th iValid is not accepted. Release iHold → writes to 1, 2, 3, 4 in order on 4 consecutive cycles; oReady rises the cycle after the first drain.
- Forward newest: iHold = 1, push {7, 0xA}, then {7, 0xB}, with iLookA = 7, iLookB = 5 → oHitA = 1, oFwdA = 0xB, oHitB = 0, oFwdB = 0.
- Register 0: push {0, 0xFFFF} → handshake completes, oCount stays 0, oWrite never asserts; iLookA = 0 → oHitA = 0.
- Wrap and simultaneous push/drain: stream 10 back-to-back pushes {i+1, i} with iHold = 0 → oCount stays 1 and writes appear in order with 1-cycle latency; pointers wrap past DEPTH with no loss or duplication.
